// File: rtl/lut_pipeline_if.sv
// Lookup/write bus for lut_pipeline. The front end drives requests and writes.
// The table drives back ready, the looked-up value and its strobe, and the overrun flag.
interface lut_pipeline_if #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 3
);
    logic                  in_valid;
    logic [LOG2_DEPTH-1:0] in;
    logic                  wr_en;
    logic [LOG2_DEPTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  ready;
    logic [WIDTH-1:0]      out;
    logic                  strobe;
    logic                  overrun;

    modport master (
        output in_valid, in, wr_en, wr_addr, wr_data,
        input  ready, out, strobe, overrun
    );

    modport slave (
        input  in_valid, in, wr_en, wr_addr, wr_data,
        output ready, out, strobe, overrun
    );
endinterface

// File: rtl/lut_pipeline.sv
// Runtime-writable lookup table. It fills itself after reset and then serves one
// lookup per cycle through a two-stage registered read pipeline.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | filling lut[idx] with the init pattern, requests dropped
// ST_RUN  | table ready, lookups and writes accepted until next reset
module lut_pipeline #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 3,
    parameter int INIT_MODE  = 0
) (
    input logic           clock,
    input logic           reset,
    lut_pipeline_if.slave bus
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int VW    = WIDTH + LOG2_DEPTH + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [LOG2_DEPTH-1:0] idx;
    logic [LOG2_DEPTH-1:0] l;
    logic                  v1;
    logic [WIDTH-1:0]      lut [DEPTH];
    logic                  ready;

    // The sum is formed wide and then cut, so entry i wraps modulo 2**WIDTH.
    function automatic logic [WIDTH-1:0] init_value(input logic [LOG2_DEPTH-1:0] i);
        logic [VW-1:0] v;
        v = VW'(i) + VW'(INIT_MODE == 0);
        return v[WIDTH-1:0];
    endfunction

    assign ready     = (state == ST_RUN);
    assign bus.ready = ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_INIT;
            idx         <= '0;
            l           <= '0;
            v1          <= 1'b0;
            bus.strobe  <= 1'b0;
            bus.out     <= '0;
            bus.overrun <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    idx <= idx + LOG2_DEPTH'(1);
                    if (idx == LOG2_DEPTH'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase

            v1 <= bus.in_valid && ready;
            if (bus.in_valid && ready) begin
                l <= bus.in;
            end

            // The table write below lands at the same edge, so this read sees the old value.
            bus.strobe <= v1;
            if (v1) begin
                bus.out <= lut[l];
            end

            if ((bus.in_valid || bus.wr_en) && !ready) begin
                bus.overrun <= 1'b1;
            end
        end
    end

    // Storage has no reset: the fill sequence rewrites every entry after each reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                lut[idx] <= init_value(idx);
            end else if (bus.wr_en) begin
                lut[bus.wr_addr] <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_lut_pipeline.sv
// Bench for lut_pipeline. Three configurations share one stimulus stream and are
// checked every cycle against a table-and-request-queue model, plus fixed scenarios.
module tb_lut_pipeline;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_addr = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    always #5 clock = ~clock;

    lut_pipeline_if #(.WIDTH(8), .LOG2_DEPTH(3)) bus_a ();
    lut_pipeline_if #(.WIDTH(2), .LOG2_DEPTH(3)) bus_b ();
    lut_pipeline_if #(.WIDTH(8), .LOG2_DEPTH(3)) bus_c ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in       = in_addr;
    assign bus_a.wr_en    = wr_en;
    assign bus_a.wr_addr  = wr_addr;
    assign bus_a.wr_data  = wr_data;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in       = in_addr;
    assign bus_b.wr_en    = wr_en;
    assign bus_b.wr_addr  = wr_addr;
    assign bus_b.wr_data  = wr_data[1:0];
    assign bus_c.in_valid = in_valid;
    assign bus_c.in       = in_addr;
    assign bus_c.wr_en    = wr_en;
    assign bus_c.wr_addr  = wr_addr;
    assign bus_c.wr_data  = wr_data;

    lut_pipeline #(.WIDTH(8), .LOG2_DEPTH(3), .INIT_MODE(0)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    lut_pipeline #(.WIDTH(2), .LOG2_DEPTH(3), .INIT_MODE(0)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));
    lut_pipeline #(.WIDTH(8), .LOG2_DEPTH(3), .INIT_MODE(1)) dut_c (.clock(clock), .reset(reset), .bus(bus_c));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: config k has a value mask and an init offset; requests wait in a queue.
    typedef struct {
        int due;
        int addr;
    } req_t;

    logic [7:0] mask [3] = '{8'hFF, 8'h03, 8'hFF};
    int         offs [3] = '{1, 1, 0};
    logic [7:0] tbl  [3][8];
    req_t       q[$];
    int         cyc = 0;
    int         fill = 0;
    logic       exp_ready = 1'b0;
    logic       exp_strobe = 1'b0;
    logic       exp_ov = 1'b0;
    logic [7:0] exp_out [3] = '{8'h00, 8'h00, 8'h00};
    bit         cmp_en = 1'b0;

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                fill = 0;
                q.delete();
                exp_strobe = 1'b0;
                exp_ov = 1'b0;
                for (int k = 0; k < 3; k++) exp_out[k] = 8'h00;
                cmp_en = 1'b1;
            end else begin
                bit rdy;
                rdy = (fill >= 8);
                exp_strobe = 1'b0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    req_t r;
                    r = q.pop_front();
                    exp_strobe = 1'b1;
                    for (int k = 0; k < 3; k++) exp_out[k] = tbl[k][r.addr];
                end
                if (!rdy) begin
                    for (int k = 0; k < 3; k++) tbl[k][fill] = 8'((fill + offs[k]) % 256) & mask[k];
                    fill++;
                    if (in_valid || wr_en) exp_ov = 1'b1;
                end else if (wr_en) begin
                    for (int k = 0; k < 3; k++) tbl[k][wr_addr] = wr_data & mask[k];
                end
                if (in_valid && rdy) q.push_back('{cyc + 1, int'(in_addr)});
            end
            exp_ready = (fill >= 8);
        end
    end

    // Cycle-by-cycle comparison of all three configurations.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("a_ready",   32'(bus_a.ready),   32'(exp_ready));
            chk("a_strobe",  32'(bus_a.strobe),  32'(exp_strobe));
            chk("a_overrun", 32'(bus_a.overrun), 32'(exp_ov));
            chk("a_out",     32'(bus_a.out),     32'(exp_out[0]));
            chk("b_ready",   32'(bus_b.ready),   32'(exp_ready));
            chk("b_strobe",  32'(bus_b.strobe),  32'(exp_strobe));
            chk("b_overrun", 32'(bus_b.overrun), 32'(exp_ov));
            chk("b_out",     32'(bus_b.out),     32'(exp_out[1]));
            chk("c_ready",   32'(bus_c.ready),   32'(exp_ready));
            chk("c_strobe",  32'(bus_c.strobe),  32'(exp_strobe));
            chk("c_overrun", 32'(bus_c.overrun), 32'(exp_ov));
            chk("c_out",     32'(bus_c.out),     32'(exp_out[2]));
        end
    end

    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] got_c[$];

    task automatic step();
        @(negedge clock);
        if (bus_a.strobe === 1'b1) got_a.push_back(bus_a.out);
        if (bus_b.strobe === 1'b1) got_b.push_back({6'b0, bus_b.out});
        if (bus_c.strobe === 1'b1) got_c.push_back(bus_c.out);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic clear_got();
        got_a.delete();
        got_b.delete();
        got_c.delete();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus_a.ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_timeout", 32'(bus_a.ready), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        idle();
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    task automatic lookup_one(input logic [2:0] a);
        clear_got();
        in_valid = 1'b1;
        in_addr  = a;
        step();
        idle();
        repeat (4) step();
    endtask

    initial begin
        // Reset, then idle through the fill.
        do_reset(3);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("init_ready", 32'(bus_a.ready), (i == 8) ? 32'd1 : 32'd0);
            chk("init_strobe", 32'(bus_a.strobe), 32'd0);
        end
        chk("init_out", 32'(bus_a.out), 32'd0);
        chk("init_overrun", 32'(bus_a.overrun), 32'd0);

        // Back-to-back lookups 0..7.
        clear_got();
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                in_valid = 1'b1;
                in_addr  = 3'(t);
            end else begin
                idle();
            end
            step();
        end
        chk("b2b_count", 32'(got_a.size()), 32'd8);
        for (int j = 0; j < 8 && j < got_a.size(); j++) chk("b2b_value", 32'(got_a[j]), 32'(j + 1));

        // Write collision at address 5.
        clear_got();
        in_valid = 1'b1;
        in_addr  = 3'd5;
        step();
        wr_en    = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 8'hA5;
        step();
        idle();
        repeat (4) step();
        chk("coll_count", 32'(got_a.size()), 32'd2);
        if (got_a.size() == 2) begin
            chk("coll_old", 32'(got_a[0]), 32'd6);
            chk("coll_new", 32'(got_a[1]), 32'hA5);
        end

        // Requests and writes during INIT are dropped and flag overrun.
        do_reset(1);
        clear_got();
        step();
        in_valid = 1'b1;
        in_addr  = 3'd2;
        wr_en    = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 8'hFF;
        step();
        idle();
        wait_ready();
        step();
        chk("ovr_flag", 32'(bus_a.overrun), 32'd1);
        chk("ovr_no_strobe", 32'(got_a.size()), 32'd0);
        lookup_one(3'd2);
        chk("ovr_lookup2", (got_a.size() == 1) ? 32'(got_a[0]) : 32'hDEAD, 32'd3);

        // Reset right behind a lookup of 3, after reprogramming entry 3.
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 8'h55;
        step();
        idle();
        clear_got();
        in_valid = 1'b1;
        in_addr  = 3'd3;
        step();
        idle();
        reset = 1'b1;
        step();
        chk("rst_ready", 32'(bus_a.ready), 32'd0);
        reset = 1'b0;
        repeat (3) step();
        chk("rst_no_strobe", 32'(got_a.size()), 32'd0);
        wait_ready();
        lookup_one(3'd3);
        chk("rst_lookup3", (got_a.size() == 1) ? 32'(got_a[0]) : 32'hDEAD, 32'd4);

        // Narrow width truncation and identity pattern.
        lookup_one(3'd7);
        chk("w2_lookup7", (got_b.size() == 1) ? 32'(got_b[0]) : 32'hDEAD, 32'd0);
        chk("id_lookup7", (got_c.size() == 1) ? 32'(got_c[0]) : 32'hDEAD, 32'd7);
        lookup_one(3'd6);
        chk("id_lookup6", (got_c.size() == 1) ? 32'(got_c[0]) : 32'hDEAD, 32'd6);
        chk("w2_lookup6", (got_b.size() == 1) ? 32'(got_b[0]) : 32'hDEAD, 32'd3);

        // Randomised traffic with occasional resets; the per-cycle compare does the checking.
        for (int t = 0; t < 3000; t++) begin
            reset    = ($urandom_range(0, 149) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_addr  = 3'($urandom_range(0, 7));
            wr_en    = $urandom_range(0, 2) == 0;
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom_range(0, 255));
            step();
        end
        idle();
        reset = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lut_pipeline.md
# lut_pipeline

Parametrised, runtime-writable lookup table with a two-stage registered read pipeline, valid/strobe handshake and a self-initialising fill state machine. It is the successor of the fixed 8-entry increment LUT. It adds a generic depth and width, a selectable init pattern and a write port for reprogramming. It also adds a ready indication and a sticky overrun flag. It sits between an index-producing front end and any consumer that needs a table-mapped value one result per cycle.

## Interface
- WIDTH, 8, data width of each table entry and of `out`
- LOG2_DEPTH, 3, address width; DEPTH = 2**LOG2_DEPTH entries
- INIT_MODE, 0, fill pattern: 0 = entry i holds i+1, 1 = entry i holds i (identity)

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  lookup request qualifier
- in  in  LOG2_DEPTH  lookup address
- wr_en  in  1  table write strobe
- wr_addr  in  LOG2_DEPTH  write address
- wr_data  in  WIDTH  write data
- ready  out  1  table initialised, requests accepted
- out  out  WIDTH  looked-up value, valid when `strobe`=1
- strobe  out  1  one-cycle pulse per accepted request
- overrun  out  1  sticky: request or write arrived while `ready`=0

## Operation
- States: INIT, RUN. Reset forces INIT, fill index `idx`=0, pipeline valids cleared, `ready`=0, `strobe`=0, `out`=0, `overrun`=0.
- INIT: each cycle writes `lut[idx]` with the INIT_MODE value, then `idx`=`idx`+1. After writing entry DEPTH-1, go to RUN and set `ready`=1. All DEPTH entries are filled, including the last one.
- Init value width rule: i+1 (or i) is truncated to WIDTH bits, i.e. modulo 2**WIDTH. Example: WIDTH=2, DEPTH=8 gives entry 3 = 0 and entry 7 = 0.
- RUN: `ready` stays 1 until the next reset. There is no way back to INIT except reset.
- Lookup, stage 1: if `in_valid` && `ready`, register `in` into address register `l` and set v1=1. Otherwise v1=0.
- Lookup, stage 2: `out` <= `lut[l]` when v1=1, and `strobe` <= v1. `out` holds its last value when `strobe`=0.
- Write: if `wr_en` && `ready`, then `lut[wr_addr]` <= `wr_data`. Writes are independent of lookups, and both may occur every cycle.
- Read/write collision: a stage-2 read of the address being written in the same cycle returns the OLD value (read-before-write). The next read returns the new value.
- `in_valid` or `wr_en` while `ready`=0 is dropped with no table or pipeline effect, and sets `overrun`=1. `overrun` is cleared only by reset.
- There is no backpressure: the consumer must accept one result per cycle.

## Timing
- Init: with reset low, rising edges 1..DEPTH write entries 0..DEPTH-1. `ready` reads 1 after edge DEPTH, i.e. 8 cycles for DEPTH=8.
- Lookup latency: request sampled at edge N, `out`/`strobe` valid after edge N+2. Throughput is 1 per cycle.
- Write latency: a write at edge N is visible to a stage-2 read at edge N+1 or later.
- Reset mid-operation: at the reset edge, in-flight requests are discarded with no `strobe`. `ready` drops the same edge, the fill restarts from entry 0, and prior writes are overwritten by the init pattern.
- Reset held for multiple cycles: outputs remain at reset values. INIT starts counting at the first edge with reset low.

## Test plan
- Reset, then idle (WIDTH=8, LOG2_DEPTH=3, INIT_MODE=0) -> `ready`=0 for 8 edges, then 1. `strobe`, `out` and `overrun` stay 0 throughout.
- Back-to-back lookups 0..7 with `in_valid`=1 every cycle after ready -> `strobe`=1 for 8 consecutive cycles starting 2 cycles later, with `out`=1,2,...,8.
- Write `lut[5]`=0xA5, reading address 5 in the same cycle and again the next cycle -> the first `out`=6 (old value), the second `out`=0xA5.
- `in_valid`=1 and `wr_en`=1 (addr 2, data 0xFF) during INIT -> `overrun`=1 and no `strobe`. After ready, a lookup of 2 returns 3.
- Reset asserted one edge after issuing lookup of 3 -> no `strobe` appears and `ready`=0. After re-init, a lookup of 3 returns 4.
- Configuration WIDTH=2, INIT_MODE=0 and configuration INIT_MODE=1 -> lookup 7 returns 0 (truncation). With identity mode, lookup 6 returns 6.
